// File: rtl/alu_sequencer_if.sv
// Memory and ALU connection bundle for alu_sequencer.
// The master modport is the sequencer side; slave is the memory/ALU side.
interface alu_sequencer_if;
   logic       imemReq;
   logic [7:0] imemAddr;
   logic       imemValid;
   logic [7:0] imemData;

   logic       dmemReq;
   logic       dmemWe;
   logic [4:0] dmemAddr;
   logic [7:0] dmemWData;
   logic       dmemValid;
   logic [7:0] dmemRData;

   logic [7:0] aluA;
   logic [7:0] aluB;
   logic [1:0] aluCtrl;
   logic [7:0] aluPc;
   logic [7:0] aluResult;

   modport master (
      output imemReq, imemAddr,
      input  imemValid, imemData,
      output dmemReq, dmemWe, dmemAddr, dmemWData,
      input  dmemValid, dmemRData,
      output aluA, aluB, aluCtrl, aluPc,
      input  aluResult
   );

   modport slave (
      input  imemReq, imemAddr,
      output imemValid, imemData,
      input  dmemReq, dmemWe, dmemAddr, dmemWData,
      output dmemValid, dmemRData,
      input  aluA, aluB, aluCtrl, aluPc,
      output aluResult
   );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/operand/execute controller for the 8-bit accumulator machine.
// Define SEQ_TIMEOUT_EN to add the memory-handshake timeout and FAULT state.
module alu_sequencer #(
   parameter logic [7:0] RESET_PC       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  resetN,
   alu_sequencer_if.master       bus,
   output logic [7:0]            acc,
   output logic                  halted,
   output logic                  fault
);

   typedef enum logic [2:0] {
      ST_FETCH, ST_MEM, ST_EXEC, ST_HALT, ST_FAULT
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD, OP_NAND, OP_BNZ, OP_SLT, OP_LD, OP_ST, OP_LDI, OP_HALT
   } op_e;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("alu_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] mdr_q, mdr_d;
   logic       imem_req_q, imem_req_d;
   logic       dmem_req_q, dmem_req_d;
   logic       dmem_we_q, dmem_we_d;
   logic [1:0] alu_ctrl_q, alu_ctrl_d;
   logic       halted_q, halted_d;
   op_e        op;

`ifdef SEQ_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) < 4) ? 4 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             fault_q, fault_d;
   logic             waiting;
`endif

   assign op = op_e'(ir_q[7:5]);

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;

      case (state_q)
         ST_FETCH: begin
            if (imem_req_q && bus.imemValid) begin
               ir_d = bus.imemData;
               case (bus.imemData[7:5])
                  3'b110:  state_d = ST_EXEC;
                  3'b111:  state_d = ST_HALT;
                  default: state_d = ST_MEM;
               endcase
            end
         end
         ST_MEM: begin
            if (dmem_req_q && bus.dmemValid) begin
               if (op == OP_ST) begin
                  pc_d    = pc_q + 8'd1;
                  state_d = ST_FETCH;
               end else begin
                  mdr_d   = bus.dmemRData;
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_q + 8'd1;
            case (op)
               OP_BNZ:  pc_d  = bus.aluResult;
               OP_LD:   acc_d = mdr_q;
               OP_LDI:  acc_d = {3'b000, ir_q[4:0]};
               default: acc_d = bus.aluResult;
            endcase
         end
         default: state_d = state_q;
      endcase

`ifdef SEQ_TIMEOUT_EN
      // A stalled handshake never changes state, so the counter only needs clearing on a transition.
      waiting   = (imem_req_q && !bus.imemValid) || (dmem_req_q && !bus.dmemValid);
      tmo_cnt_d = tmo_cnt_q;
      if (waiting) begin
         if (tmo_cnt_q == TMO_LAST) state_d = ST_FAULT;
         else                       tmo_cnt_d = tmo_cnt_q + 1'b1;
      end else if (state_d != state_q) begin
         tmo_cnt_d = '0;
      end
      fault_d = (state_d == ST_FAULT);
`endif

      imem_req_d = (state_d == ST_FETCH);
      dmem_req_d = (state_d == ST_MEM);
      dmem_we_d  = (state_d == ST_MEM) && (ir_d[7:5] == OP_ST);
      alu_ctrl_d = (state_d == ST_EXEC) ? ir_d[6:5] : 2'b00;
      halted_d   = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is tested inside the clocked block, making it synchronous; outputs reset to idle too.
      if (!resetN) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         acc_q      <= 8'h00;
         ir_q       <= 8'h00;
         mdr_q      <= 8'h00;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         alu_ctrl_q <= 2'b00;
         halted_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         acc_q      <= acc_d;
         ir_q       <= ir_d;
         mdr_q      <= mdr_d;
         imem_req_q <= imem_req_d;
         dmem_req_q <= dmem_req_d;
         dmem_we_q  <= dmem_we_d;
         alu_ctrl_q <= alu_ctrl_d;
         halted_q   <= halted_d;
`ifdef SEQ_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         fault_q    <= fault_d;
`endif
      end
   end

   assign bus.imemReq   = imem_req_q;
   assign bus.imemAddr  = pc_q;
   assign bus.dmemReq   = dmem_req_q;
   assign bus.dmemWe    = dmem_we_q;
   assign bus.dmemAddr  = ir_q[4:0];
   assign bus.dmemWData = acc_q;
   assign bus.aluA      = acc_q;
   assign bus.aluB      = mdr_q;
   assign bus.aluCtrl   = alu_ctrl_q;
   assign bus.aluPc     = pc_q;

   assign acc    = acc_q;
   assign halted = halted_q;
`ifdef SEQ_TIMEOUT_EN
   assign fault  = fault_q;
`else
   assign fault  = 1'b0;
`endif

endmodule
